// File: rtl/bus_arbiter_2m_pkg.sv
// bus_arbiter_2m_pkg: shared FSM encoding, bus mode values and default widths
package bus_arbiter_2m_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/bus_arbiter_2m_if.sv
// bus_arbiter_2m_if: two-master request side plus the single slave port of the arbiter
interface bus_arbiter_2m_if
  import bus_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [2*ADDR_W-1:0] m_addr;
  logic [2*DATA_W-1:0] m_wdata;
  logic [1:0] m_mode;
  logic [1:0] m_valid;
  logic [1:0] m_rready;
  logic [1:0] m_wready;
  logic [1:0] m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0] m_err;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic s_mode;
  logic s_valid;
  logic s_rready;
  logic s_wready;
  logic s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0] gnt;
  modport slave (
    input m_addr, m_wdata, m_mode, m_valid, m_rready, s_wready, s_rvalid, s_rdata,
    output m_wready, m_rvalid, m_rdata, m_err, s_addr, s_wdata, s_mode, s_valid, s_rready, gnt
  );
  modport master (
    output m_addr, m_wdata, m_mode, m_valid, m_rready, s_wready, s_rvalid, s_rdata,
    input m_wready, m_rvalid, m_rdata, m_err, s_addr, s_wdata, s_mode, s_valid, s_rready, gnt
  );
endinterface

// File: rtl/bus_arbiter_2m_rr_arb2.sv
// rr_arb2: two-input round-robin picker, ptr selects the winner only on contention
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = &req ? (ptr ? 2'b10 : 2'b01) : (req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00));
  end
endmodule

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: whole-transaction round-robin arbiter of two masters onto one slave with timeout release
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TMO_CYC = 255
) (
  input logic clk,
  input logic rst,
  bus_arbiter_2m_if.slave bus
);
  state_t state, state_nx;
  logic [1:0] pick, gnt_q, err_q;
  logic rr_ptr, g, busy, act, done, abort, tmo;
  logic [7:0] tmo_cnt;
  rr_arb2 u_rr (.req(bus.m_valid), .ptr(rr_ptr), .gnt(pick));
  assign g = gnt_q[1];
  assign busy = state == ST_BUSY;
  assign act = busy & ~rst;
  // done outranks abort, which outranks timeout, so a late completion never raises m_err
  assign done = busy & (bus.m_mode[g] == MODE_WRITE ? bus.m_valid[g] & bus.s_wready
                                                     : bus.s_rvalid & bus.m_rready[g]);
  assign abort = busy & ~bus.m_valid[g] & ~done;
  assign tmo = busy & ~done & ~abort & (tmo_cnt == 8'(TMO_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= 2'b00;
      rr_ptr <= 1'b0;
      tmo_cnt <= 8'd0;
      err_q <= 2'b00;
    end else begin
      gnt_q <= state_nx == ST_BUSY ? (busy ? gnt_q : pick) : 2'b00;
      rr_ptr <= done | tmo ? ~g : rr_ptr;
      tmo_cnt <= busy && state_nx == ST_BUSY ? tmo_cnt + 8'd1 : 8'd0;
      err_q <= tmo ? gnt_q : 2'b00;
    end
  end
  always_comb begin
    state_nx = busy ? (done | abort | tmo ? ST_IDLE : ST_BUSY)
                    : (|bus.m_valid ? ST_BUSY : ST_IDLE);
  end
  always_comb begin
    bus.s_addr = act ? (g ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0]) : '0;
    bus.s_wdata = act ? (g ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0]) : '0;
    bus.s_mode = act & bus.m_mode[g];
    bus.s_valid = act & bus.m_valid[g];
    bus.s_rready = act & bus.m_rready[g];
    bus.m_wready = act & bus.s_wready ? gnt_q : 2'b00;
    bus.m_rvalid = act & bus.s_rvalid ? gnt_q : 2'b00;
    bus.m_rdata = bus.s_rdata;
    bus.m_err = err_q;
    bus.gnt = gnt_q;
  end
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed checks of the two-master arbiter against a combinational RAM slave
module tb_bus_arbiter_2m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hang_w = 1'b0;
  logic hang_r = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:255];
  bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  bus_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.s_wready = bus.s_valid & bus.s_mode & ~hang_w;
  assign bus.s_rvalid = bus.s_valid & ~bus.s_mode & ~hang_r;
  assign bus.s_rdata = mem[bus.s_addr[7:0]];
  always @(posedge clk) if (bus.s_valid & bus.s_mode & bus.s_wready) mem[bus.s_addr[7:0]] <= bus.s_wdata;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.m_addr = {32'h20, 32'h20};
    bus.m_wdata = {32'h0, 32'hDEAD_BEEF};
    bus.m_mode = 2'b01;
    bus.m_valid = 2'b11;
    bus.m_rready = 2'b11;
    repeat (3) tick();
    chk2("rst_gnt", bus.gnt, 2'b00);
    chk1("rst_s_valid", bus.s_valid, 1'b0);
    chk2("rst_wready", bus.m_wready, 2'b00);
    chk2("rst_rvalid", bus.m_rvalid, 2'b00);
    chk2("rst_err", bus.m_err, 2'b00);
    chk32("rst_s_addr", bus.s_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk1("idle_s_valid", bus.s_valid, 1'b0);
    tick();
    chk2("cont_gnt_m0", bus.gnt, 2'b01);
    chk2("cont_wready", bus.m_wready, 2'b01);
    tick();
    bus.m_valid = 2'b10;
    chk2("cont_gnt_idle", bus.gnt, 2'b00);
    chk32("cont_mem", mem[8'h20], 32'hDEAD_BEEF);
    tick();
    chk2("cont_gnt_m1", bus.gnt, 2'b10);
    chk2("cont_rvalid", bus.m_rvalid, 2'b10);
    chk32("cont_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    tick();
    bus.m_valid = 2'b00;
    chk2("cont_gnt_end", bus.gnt, 2'b00);
    bus.m_addr = {32'h0, 32'h10};
    bus.m_wdata = {32'h0, 32'hA5A5_0001};
    bus.m_mode = 2'b01;
    bus.m_valid = 2'b01;
    tick();
    chk2("solo_gnt", bus.gnt, 2'b01);
    chk2("solo_wready", bus.m_wready, 2'b01);
    chk32("solo_s_addr", bus.s_addr, 32'h10);
    chk32("solo_s_wdata", bus.s_wdata, 32'hA5A5_0001);
    tick();
    bus.m_valid = 2'b00;
    chk2("solo_gnt_end", bus.gnt, 2'b00);
    chk32("solo_mem", mem[8'h10], 32'hA5A5_0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_addr = {32'h10, 32'h30};
    bus.m_wdata = {32'h0, 32'h0BAD_F00D};
    bus.m_mode = 2'b01;
    bus.m_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk2("fair_gnt", bus.gnt, i % 2 == 1 ? 2'b10 : 2'b01);
      if (i == 1) chk32("fair_rdata", bus.m_rdata, 32'hA5A5_0001);
      tick();
      chk2("fair_bubble", bus.gnt, 2'b00);
    end
    bus.m_valid = 2'b00;
    hang_w = 1'b1;
    bus.m_valid = 2'b11;
    tick();
    chk2("tmo_gnt", bus.gnt, 2'b01);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk2("tmo_err_quiet", bus.m_err, 2'b00);
    end
    chk2("tmo_gnt_held", bus.gnt, 2'b01);
    tick();
    chk2("tmo_err", bus.m_err, 2'b01);
    chk2("tmo_gnt_rel", bus.gnt, 2'b00);
    chk1("tmo_s_valid", bus.s_valid, 1'b0);
    tick();
    chk2("tmo_err_pulse", bus.m_err, 2'b00);
    chk2("tmo_next_gnt", bus.gnt, 2'b10);
    chk2("tmo_next_rvalid", bus.m_rvalid, 2'b10);
    tick();
    bus.m_valid = 2'b00;
    chk2("tmo_next_end", bus.gnt, 2'b00);
    bus.m_addr = {32'h0, 32'h40};
    bus.m_wdata = {32'h0, 32'h1234_5678};
    bus.m_valid = 2'b01;
    tick();
    chk2("late_gnt", bus.gnt, 2'b01);
    repeat (7) tick();
    hang_w = 1'b0;
    #1;
    chk2("late_wready", bus.m_wready, 2'b01);
    tick();
    bus.m_valid = 2'b00;
    chk2("late_no_err", bus.m_err, 2'b00);
    chk2("late_gnt_end", bus.gnt, 2'b00);
    chk32("late_mem", mem[8'h40], 32'h1234_5678);
    hang_r = 1'b1;
    bus.m_mode = 2'b00;
    bus.m_valid = 2'b10;
    tick();
    chk2("abort_gnt", bus.gnt, 2'b10);
    chk2("abort_rvalid_busy", bus.m_rvalid, 2'b00);
    bus.m_valid = 2'b00;
    tick();
    chk2("abort_gnt_idle", bus.gnt, 2'b00);
    chk2("abort_rvalid", bus.m_rvalid, 2'b00);
    chk2("abort_err", bus.m_err, 2'b00);
    hang_r = 1'b0;
    hang_w = 1'b1;
    bus.m_mode = 2'b01;
    bus.m_valid = 2'b01;
    tick();
    chk2("rstmid_gnt", bus.gnt, 2'b01);
    rst = 1'b1;
    #1;
    chk1("rstmid_s_valid_now", bus.s_valid, 1'b0);
    tick();
    chk2("rstmid_gnt_rst", bus.gnt, 2'b00);
    chk1("rstmid_s_valid", bus.s_valid, 1'b0);
    chk2("rstmid_err", bus.m_err, 2'b00);
    rst = 1'b0;
    bus.m_valid = 2'b00;
    tick();
    chk2("rstmid_idle", bus.gnt, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
